// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access sizes,
// byte-lane enable and store-data replication.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 4'b0001 << lo;
            SZ_HALF: return 4'b0011 << lo;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate the store value across lanes so the bus only needs bus_sel.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lane_align.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it.
module lane_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [15:0] sh;

    always_comb begin
        sh = 16'(rdata >> {addr_lo, 3'b000});
        case (size)
            SZ_BYTE: data = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: data = uns ? {16'd0, sh}      : {{16{sh[15]}}, sh};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/data_mem_handler.sv
// Load/store unit: turns a core load/store into a stalled bus transaction with
// byte lanes, alignment checking, bus timeout and extended load data.
module data_mem_handler
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] read_address,
    input  logic [31:0] write_address,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        done,
    output logic        mis_err,
    output logic        bus_err
);

    state_e      state_q, state_d;
    logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d, load_data_q, load_data_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic        bus_read_q, bus_read_d, bus_write_q, bus_write_d;
    logic        done_q, done_d, mis_err_q, mis_err_d, bus_err_q, bus_err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  addr_lo_q, addr_lo_d, size_q, size_d;
    logic        uns_q, uns_d, is_load_q, is_load_d;

    logic        req, both, illegal, misal;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] aligned;

    lane_align u_align (
        .rdata   (bus_rdata),
        .addr_lo (addr_lo_q),
        .size    (size_q),
        .uns     (uns_q),
        .data    (aligned)
    );

    always_comb begin
        req     = mem_read ^ mem_write;
        both    = mem_read & mem_write;
        addr    = mem_read ? read_address : write_address;
        size    = funct3[1:0];
        illegal = (size == 2'b11) || (funct3[2] && (size == SZ_WORD || mem_write));
        misal   = (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00);

        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        bus_read_d  = bus_read_q;
        bus_write_d = bus_write_q;
        load_data_d = load_data_q;
        done_d      = 1'b0;
        mis_err_d   = mis_err_q;
        bus_err_d   = bus_err_q;
        cnt_d       = cnt_q;
        addr_lo_d   = addr_lo_q;
        size_d      = size_q;
        uns_d       = uns_q;
        is_load_d   = is_load_q;
        stall       = 1'b0;

        case (state_q)
            IDLE: begin
                stall = mem_read | mem_write;
                if (req) begin
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_sel_d   = lane_sel(size, addr[1:0]);
                    bus_wdata_d = lane_wdata(size, store_data);
                    addr_lo_d   = addr[1:0];
                    size_d      = size;
                    uns_d       = funct3[2];
                    is_load_d   = mem_read;
                    if (illegal || misal) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        mis_err_d = 1'b1;
                        if (mem_read) load_data_d = '0;
                    end else begin
                        state_d     = ACCESS;
                        bus_read_d  = mem_read;
                        bus_write_d = mem_write;
                        cnt_d       = '0;
                    end
                end else if (both) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    mis_err_d   = 1'b1;
                    load_data_d = '0;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (bus_ack || cnt_q == 16'(TIMEOUT - 1)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    bus_read_d  = 1'b0;
                    bus_write_d = 1'b0;
                    bus_err_d   = !bus_ack;
                    if (is_load_q) load_data_d = bus_ack ? aligned : '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                mis_err_d = 1'b0;
                bus_err_d = 1'b0;
            end
        endcase

        // Reset must kill the stall immediately even while control still holds a request.
        if (!nRst) stall = 1'b0;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= IDLE;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= '0;
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            load_data_q <= '0;
            done_q      <= 1'b0;
            mis_err_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
            addr_lo_q   <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            is_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            bus_read_q  <= bus_read_d;
            bus_write_q <= bus_write_d;
            load_data_q <= load_data_d;
            done_q      <= done_d;
            mis_err_q   <= mis_err_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
            addr_lo_q   <= addr_lo_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            is_load_q   <= is_load_d;
        end
    end

    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_sel   = bus_sel_q;
    assign bus_read  = bus_read_q;
    assign bus_write = bus_write_q;
    assign load_data = load_data_q;
    assign done      = done_q;
    assign mis_err   = mis_err_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_data_mem_handler.sv
// Directed bench for data_mem_handler: loads, stores, lane extraction, errors,
// timeout and mid-transaction reset.
module tb_data_mem_handler;

    logic        clk = 1'b0;
    logic        nRst;
    logic        mem_read, mem_write, bus_ack;
    logic [2:0]  funct3;
    logic [31:0] read_address, write_address, store_data, bus_rdata;
    logic [31:0] bus_addr, bus_wdata, load_data;
    logic [3:0]  bus_sel;
    logic        bus_read, bus_write, stall, done, mis_err, bus_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_handler #(.TIMEOUT(4)) dut (
        .clk(clk), .nRst(nRst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .read_address(read_address), .write_address(write_address),
        .store_data(store_data), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .bus_read(bus_read), .bus_write(bus_write), .load_data(load_data),
        .stall(stall), .done(done), .mis_err(mis_err), .bus_err(bus_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        mem_read = rd; mem_write = wr; funct3 = f3;
        read_address = a; write_address = a; store_data = d;
    endtask

    task automatic idle_in();
        mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        idle_in(); drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0); bus_rdata = '0;
        nRst = 1'b0;
        #12;
        checks++;
        if ({bus_addr, bus_wdata, bus_sel, load_data} !== 100'd0) begin
            failures++; $display("FAIL reset_data addr=%h wdata=%h sel=%b ld=%h", bus_addr, bus_wdata, bus_sel, load_data);
        end
        checks++;
        if ({bus_read, bus_write, stall, done, mis_err, bus_err} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000000", {bus_read, bus_write, stall, done, mis_err, bus_err});
        end
        nRst = 1'b1;
    endtask

    task automatic test_lw();
        step(); drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0); #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL lw_stall_idle got=%b exp=1", stall); end
        step();
        checks++;
        if ({bus_read, bus_write, stall, done} !== 4'b1010) begin
            failures++; $display("FAIL lw_access got=%b exp=1010", {bus_read, bus_write, stall, done});
        end
        checks++;
        if (bus_addr !== 32'h100 || bus_sel !== 4'b1111) begin
            failures++; $display("FAIL lw_addr_sel addr=%h sel=%b exp 00000100/1111", bus_addr, bus_sel);
        end
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        step(); idle_in();
        checks++;
        if ({bus_read, stall, done, mis_err, bus_err} !== 5'b00100) begin
            failures++; $display("FAIL lw_done got=%b exp=00100", {bus_read, stall, done, mis_err, bus_err});
        end
        checks++;
        if (load_data !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", load_data); end
        step();
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL lw_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_lb_lbu();
        logic [2:0]  f3  [2] = '{3'b000, 3'b100};
        logic [31:0] exp [2] = '{32'hFFFFFF80, 32'h00000080};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, f3[i], 32'h103, 32'h0);
            step();
            checks++;
            if (bus_sel !== 4'b1000 || bus_read !== 1'b1) begin
                failures++; $display("FAIL lb_sel[%0d] sel=%b rd=%b exp 1000/1", i, bus_sel, bus_read);
            end
            bus_ack = 1'b1; bus_rdata = 32'h80FF0000;
            step(); idle_in();
            checks++;
            if (done !== 1'b1 || load_data !== exp[i]) begin
                failures++; $display("FAIL lb_data[%0d] done=%b got=%h exp=%h", i, done, load_data, exp[i]);
            end
            step();
        end
    endtask

    task automatic test_sh();
        int hi;
        drive(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD);
        step();
        checks++;
        if (bus_addr !== 32'h200 || bus_sel !== 4'b1100 || bus_wdata !== 32'hABCDABCD) begin
            failures++; $display("FAIL sh_bus addr=%h sel=%b wdata=%h exp 00000200/1100/abcdabcd", bus_addr, bus_sel, bus_wdata);
        end
        hi = int'(bus_write);
        step(); hi += int'(bus_write);
        step(); hi += int'(bus_write);
        bus_ack = 1'b1; bus_rdata = 32'h55555555;
        step(); idle_in();
        checks++;
        if (hi !== 3) begin failures++; $display("FAIL sh_write_cycles got=%0d exp=3", hi); end
        checks++;
        if ({bus_write, done, mis_err, bus_err} !== 4'b0100 || load_data !== 32'h00000080) begin
            failures++; $display("FAIL sh_done flags=%b ld=%h exp 0100/00000080", {bus_write, done, mis_err, bus_err}, load_data);
        end
        step();
    endtask

    task automatic test_misaligned();
        logic        rd  [2] = '{1'b0, 1'b1};
        logic [2:0]  f3  [2] = '{3'b100, 3'b010};
        logic [31:0] ad  [2] = '{32'h204, 32'h101};
        logic [31:0] exp [2] = '{32'h00000080, 32'h00000000};
        for (int i = 0; i < 2; i++) begin
            drive(rd[i], !rd[i], f3[i], ad[i], 32'hFFFFFFFF);
            #1;
            checks++;
            if (stall !== 1'b1) begin failures++; $display("FAIL mis_stall[%0d] got=%b exp=1", i, stall); end
            step();
            checks++;
            if ({bus_read, bus_write, stall, done, mis_err, bus_err} !== 6'b000110 || load_data !== exp[i]) begin
                failures++; $display("FAIL mis_done[%0d] flags=%b ld=%h exp 000110/%h", i,
                    {bus_read, bus_write, stall, done, mis_err, bus_err}, load_data, exp[i]);
            end
            idle_in();
            step();
            checks++;
            if ({done, mis_err} !== 2'b00) begin failures++; $display("FAIL mis_clear[%0d] got=%b exp=00", i, {done, mis_err}); end
        end
    endtask

    task automatic test_both();
        drive(1'b1, 1'b1, 3'b010, 32'h100, 32'h0);
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL both_stall got=%b exp=1", stall); end
        step(); idle_in();
        checks++;
        if ({bus_read, bus_write, done, mis_err} !== 4'b0011) begin
            failures++; $display("FAIL both_done got=%b exp=0011", {bus_read, bus_write, done, mis_err});
        end
        step();
    endtask

    task automatic test_timeout();
        int hi = 0;
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        step(); bus_ack = 1'b1; bus_rdata = 32'h12345678;
        step(); idle_in(); step();
        checks++;
        if (load_data !== 32'h12345678) begin failures++; $display("FAIL to_preload got=%h exp=12345678", load_data); end
        drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
        step();
        for (int c = 0; c < 20 && bus_read; c++) begin
            hi++;
            step();
        end
        idle_in();
        checks++;
        if (hi !== 4) begin failures++; $display("FAIL to_read_cycles got=%0d exp=4", hi); end
        checks++;
        if ({done, bus_err, mis_err} !== 3'b110 || load_data !== 32'h0) begin
            failures++; $display("FAIL to_done flags=%b ld=%h exp 110/00000000", {done, bus_err, mis_err}, load_data);
        end
        step();
        checks++;
        if (bus_err !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", bus_err); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        step();
        checks++;
        if (bus_read !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=%b exp=1", bus_read); end
        nRst = 1'b0;
        #1;
        checks++;
        if ({bus_read, stall, done} !== 3'b000) begin
            failures++; $display("FAIL rst_mid_drop got=%b exp=000", {bus_read, stall, done});
        end
        idle_in();
        step(); step();
        nRst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", seen); end
        drive(1'b1, 1'b0, 3'b010, 32'h404, 32'h0);
        step(); bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        step(); idle_in();
        checks++;
        if (done !== 1'b1 || load_data !== 32'hCAFEF00D) begin
            failures++; $display("FAIL rst_mid_next done=%b ld=%h exp 1/cafef00d", done, load_data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_misaligned();
        test_both();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_handler.md
Name: data_mem_handler

Overview:
Sequential load/store unit on the far side of the ALU's read_address/write_address outputs in the RV32I single-cycle core. Turns a load/store (address from ALU, size from funct3) into a bus transaction with byte lanes. Stalls the core until the bus acknowledges, then returns aligned, sign- or zero-extended load data. Detects misaligned accesses, illegal sizes and bus timeouts.

Parameters:
TIMEOUT, 255, ACCESS-state cycles without bus_ack before abort (1..65535)

Ports:
clk  in  1  system clock
nRst  in  1  asynchronous active-low reset
mem_read  in  1  load request level from control, held while stall=1
mem_write  in  1  store request level from control, held while stall=1
funct3  in  3  instruction funct3 (size/sign)
read_address  in  32  ALU-computed load address
write_address  in  32  ALU-computed store address
store_data  in  32  rs2 value for stores
bus_rdata  in  32  bus read data, valid when bus_ack=1
bus_ack  in  1  bus completion strobe
bus_addr  out  32  word-aligned bus address
bus_wdata  out  32  lane-replicated store data
bus_sel  out  4  byte enables
bus_read  out  1  read strobe
bus_write  out  1  write strobe
load_data  out  32  extended load result, held until next load completes
stall  out  1  freeze PC/register writeback
done  out  1  one-cycle completion pulse
mis_err  out  1  misaligned/illegal access flag, valid with done
bus_err  out  1  timeout flag, valid with done

Behaviour:
- Reset (async, nRst=0): state IDLE; all registered outputs 0 (bus_addr, bus_wdata, bus_sel, bus_read, bus_write, load_data, done, mis_err, bus_err, timeout count); stall=0. Applies mid-transaction: strobes drop immediately; no done pulse.
- States: IDLE, ACCESS, DONE.
- IDLE: req = mem_read ^ mem_write. stall = req (combinational). On req: capture addr (read_address for loads, write_address for stores), size, sign, store_data; compute sel/wdata.
  - Legal and aligned: -> ACCESS.
  - Misaligned, illegal size, or illegal store size: -> DONE with mis_err=1; no bus access.
  - mem_read and mem_write both 1: -> DONE with mis_err=1; stall=1 for that cycle.
- Size encoding funct3[1:0]: 00 byte, 01 half, 10 word, 11 illegal. funct3[2]=1 means unsigned (LBU/LHU); illegal with a word size or with any store.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
- bus_addr = {addr[31:2],2'b00}.
- bus_sel: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- bus_wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- ACCESS: bus_read or bus_write =1 and stall=1; addr/sel/wdata stable.
  - bus_ack=1: capture bus_rdata (loads) -> DONE.
  - Otherwise the counter increments. Reaching TIMEOUT -> DONE with bus_err=1 and load_data=0.
  - Strobes deassert in DONE.
- DONE: done=1 for exactly one cycle; stall=0; inputs ignored; -> IDLE.
  - load_data updates on DONE entry for loads only, including timeouts and errored loads (0). Stores leave it unchanged.
  - Error flags are cleared on leaving DONE.
- Load extraction: select lane by addr[1:0], then sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1).
- Latency: ack in the first ACCESS cycle -> stall high for 2 cycles, done on the 3rd cycle. Error path: done on the 2nd cycle.
- bus_ack outside ACCESS is ignored.
- Timeout counter clears on every ACCESS entry and does not wrap.

Decomposition:
- Shared package mem_pkg:
  - state enum
  - size constants SZ_BYTE/SZ_HALF/SZ_WORD
  - opcode constants LOAD 7'b0000011, STORE 7'b0100011
- One combinational sub-module, lane_align: (bus_rdata, addr[1:0], size, unsigned) -> load_data. Reused by its bench.

Test Plan:
- LW read_address=0x100, bus_ack in 1st ACCESS cycle, bus_rdata=0xDEADBEEF -> bus_sel=1111, bus_addr=0x100; stall 2 cycles; done pulse; load_data=0xDEADBEEF.
- LB 0x103 then LBU 0x103, bus_rdata=0x80FF_0000 -> bus_sel=1000; load_data=0xFFFFFF80, then 0x00000080.
- SH write_address=0x202, store_data=0x1234ABCD, ack after 3 cycles -> bus_addr=0x200, bus_sel=1100, bus_wdata=0xABCDABCD; bus_write high 3 cycles; load_data unchanged.
- LW 0x101, and separately SB with funct3=100 -> no bus_read/bus_write; done with mis_err=1 on the 2nd cycle.
- TIMEOUT=4, LW with bus_ack never asserted -> bus_read high 4 cycles; done with bus_err=1; load_data=0.
- nRst pulled low during ACCESS -> bus_read, stall, done =0 immediately; no done after release; next LW completes normally.
